// File: rtl/camgen_pkg.sv
// Shared definitions for the camera pattern generator.
//   state_e : frame FSM states (IDLE, VBLANK, ACTIVE, HBLANK)
//   mode_e  : test pattern encodings
//   cnt_w   : counter width for a range of n values (never narrower than 1 bit)
package camgen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VBLANK = 2'd1,
    ACTIVE = 2'd2,
    HBLANK = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_COUNT = 2'd0,
    MODE_HRAMP = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_CONST = 2'd3
  } mode_e;

  function automatic int unsigned cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/camgen_pclk_div.sv
// Pixel clock divider.
//   clock, reset : system clock, asynchronous active-low reset
//   run          : high while the frame FSM is out of IDLE
//   pclk         : pixel clock, toggles every CLK_DIV clocks while run, held 0 otherwise
//   fall_tick    : one-clock pulse on the cycle whose edge drives pclk low
module camgen_pclk_div
  import camgen_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic run,
  output logic pclk,
  output logic fall_tick
);

  localparam int unsigned DIV_W = cnt_w(CLK_DIV);
  localparam logic [DIV_W-1:0] TERM = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             half_q, half_d;
  logic             pclk_q, pclk_d;
  logic             terminal;

  // Idle preload (terminal count, high half) makes the first running cycle a fall event, so the
  // first pixel period starts one clock after leaving IDLE.
  always_comb begin
    terminal  = (cnt_q == TERM);
    fall_tick = run && terminal && half_q;
    cnt_d     = cnt_q;
    half_d    = half_q;
    pclk_d    = pclk_q;
    if (!run) begin
      cnt_d  = TERM;
      half_d = 1'b1;
      pclk_d = 1'b0;
    end else if (terminal) begin
      cnt_d  = '0;
      half_d = ~half_q;
      pclk_d = ~half_q;
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= TERM;
      half_q <= 1'b1;
      pclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
      pclk_q <= pclk_d;
    end
  end

  assign pclk = pclk_q;

endmodule

// File: rtl/camera_pattern_gen.sv
// DVP-style camera stimulus source: pclk/hsync/vsync/data with programmable geometry and four
// test patterns (counter, horizontal ramp, checkerboard, constant).
//   clock, reset : system clock, asynchronous active-low reset
//   enable       : run request; sampled in IDLE and at the end of each frame
//   mode         : pattern select, latched at frame start
//   pclk         : pixel clock, data valid on its rising edge
//   hsync, vsync : line/frame qualifiers
//   output_data  : pixel value, 0 outside active pixels
//   frame_done   : one-clock pulse as the last pixel period of a frame ends
// Build option: define CAMGEN_FRAME_TAG_EN to replace the first active pixel of each frame with
// the low bits of a 16-bit frame counter.
module camera_pattern_gen
  import camgen_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned H_ACTIVE    = 160,
  parameter int unsigned H_BLANK     = 140,
  parameter int unsigned V_ACTIVE    = 120,
  parameter int unsigned V_BLANK     = 10,
  parameter int unsigned VSYNC_LINES = 2,
  parameter int unsigned CLK_DIV     = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        mode,
  output logic              pclk,
  output logic              hsync,
  output logic              vsync,
  output logic [DATA_W-1:0] output_data,
  output logic              frame_done
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_BLANK;
  localparam int unsigned V_TOTAL = V_BLANK + V_ACTIVE;
  localparam int unsigned COL_W   = cnt_w(H_TOTAL);
  localparam int unsigned ROW_W   = cnt_w(V_TOTAL);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(H_TOTAL - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(V_TOTAL - 1);
  localparam logic [DATA_W-1:0] CONST_VAL = {{(DATA_W/2){1'b1}}, {(DATA_W/2){1'b0}}};

  state_e            state_q, state_d;
  mode_e             mode_q, mode_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              first_q, first_d;
  logic [DATA_W-1:0] pcount_q, pcount_d;
  logic              hsync_q, hsync_d, vsync_q, vsync_d, done_q, done_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              fall_tick, present;
  logic [DATA_W-1:0] pat;
`ifdef CAMGEN_FRAME_TAG_EN
  logic [15:0]       fcount_q;
`endif

  camgen_pclk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_pclk_div (
    .clock    (clock),
    .reset    (reset),
    .run      (state_q != IDLE),
    .pclk     (pclk),
    .fall_tick(fall_tick)
  );

  // row/col name the pixel currently on the bus; first_q marks that the first pixel of a
  // frame entered from IDLE has not been put on the bus yet.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    row_d    = row_q;
    col_d    = col_q;
    first_d  = first_q;
    pcount_d = pcount_q;
    hsync_d  = hsync_q;
    vsync_d  = vsync_q;
    data_d   = data_q;
    done_d   = 1'b0;
    present  = 1'b0;
    pat      = '0;

    unique case (state_q)
      IDLE: begin
        if (enable) begin
          state_d  = VBLANK;
          row_d    = '0;
          col_d    = '0;
          first_d  = 1'b1;
          mode_d   = mode_e'(mode);
          pcount_d = '0;
        end
      end
      VBLANK, ACTIVE, HBLANK: begin
        if (fall_tick) begin
          if (first_q) begin
            first_d = 1'b0;
            present = 1'b1;
          end else if (state_q == HBLANK && row_q == ROW_LAST && col_q == COL_LAST) begin
            done_d   = 1'b1;
            row_d    = '0;
            col_d    = '0;
            pcount_d = '0;
            if (enable) begin
              state_d = VBLANK;
              mode_d  = mode_e'(mode);
              present = 1'b1;
            end else begin
              state_d = IDLE;
              hsync_d = 1'b0;
              vsync_d = 1'b0;
              data_d  = '0;
            end
          end else begin
            present = 1'b1;
            col_d   = (col_q == COL_LAST) ? '0 : col_q + COL_W'(1);
            row_d   = (col_q == COL_LAST) ? row_q + ROW_W'(1) : row_q;
            case (state_q)
              VBLANK: if (col_q == COL_LAST && row_q == ROW_W'(V_BLANK - 1)) state_d = ACTIVE;
              ACTIVE: if (col_q == COL_W'(H_ACTIVE - 1)) state_d = HBLANK;
              HBLANK: if (col_q == COL_LAST) state_d = ACTIVE;
              default: state_d = state_q;
            endcase
          end
        end
      end
    endcase

    unique case (mode_q)
      MODE_COUNT: pat = pcount_q;
      MODE_HRAMP: pat = DATA_W'(col_d);
      MODE_CHECK: pat = (((32'(col_d) ^ (32'(row_d) - V_BLANK)) & 32'd8) != 32'd0) ? '1 : '0;
      MODE_CONST: pat = CONST_VAL;
    endcase
`ifdef CAMGEN_FRAME_TAG_EN
    if (row_d == ROW_W'(V_BLANK) && col_d == '0) pat = DATA_W'(fcount_q);
`endif

    if (present) begin
      hsync_d = (state_d == ACTIVE);
      vsync_d = (32'(row_d) < VSYNC_LINES);
      data_d  = (state_d == ACTIVE) ? pat : '0;
      // Counter advances on every active pixel, including a tagged one.
      if (state_d == ACTIVE) pcount_d = pcount_q + DATA_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      mode_q   <= MODE_COUNT;
      row_q    <= '0;
      col_q    <= '0;
      first_q  <= 1'b0;
      pcount_q <= '0;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      data_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      row_q    <= row_d;
      col_q    <= col_d;
      first_q  <= first_d;
      pcount_q <= pcount_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      data_q   <= data_d;
      done_q   <= done_d;
    end
  end

`ifdef CAMGEN_FRAME_TAG_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fcount_q <= '0;
    end else if (done_d) begin
      fcount_q <= fcount_q + 16'd1;
    end
  end
`endif

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign output_data = data_q;
  assign frame_done  = done_q;

endmodule
